// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU core, the debug read port, the arbiter and the
// unified memory.
//   slave  : arbiter view (requests and mem_rdata in; grants, responses and
//            memory drive out)
//   master : requester/memory view (mirror of slave)
// Parameter ADDR_W: memory line-index width (one line = 64 bits).
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 8
);
    // CPU port
    logic              cpu_req;
    logic [1:0]        cpu_memwrite;
    logic [63:0]       cpu_adr;
    logic [63:0]       cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [63:0]       cpu_rdata;

    // Debug read port
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [63:0]       dbg_rdata;

    // Memory port
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_be;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_memwrite, cpu_adr, cpu_wdata,
        input  dbg_req, dbg_addr,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output cpu_req, cpu_memwrite, cpu_adr, cpu_wdata,
        output dbg_req, dbg_addr,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between the CPU core (fixed
// priority) and the read-only debug port. A wait counter lets debug win once
// it has been denied MAXWAIT consecutive cycles, bounding its latency.
// Grants and memory drive are combinational (zero-latency grant); read data
// returns one cycle after the grant and is routed to the recorded owner.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset; forces every output to 0
//   bus   : mem_port_arbiter_if.slave (CPU, debug and memory signals)
// Parameters: ADDR_W line-index width, MAXWAIT debug starvation limit (1..15).
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned MAXWAIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    owner_e           rsp_owner;
    owner_e           rsp_owner_nxt;
    logic             dbg_starved;
    logic             cpu_win;
    logic             dbg_win;

    // Low byte-offset bits and bits above the line index select nothing.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{bus.cpu_adr[63:ADDR_W+3], bus.cpu_adr[1:0]};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            rsp_owner <= OWN_NONE;
        end else begin
            wait_cnt  <= wait_cnt_nxt;
            rsp_owner <= rsp_owner_nxt;
        end
    end

    // Arbitration and next-state
    always_comb begin
        dbg_starved   = (wait_cnt == CNT_W'(MAXWAIT));
        cpu_win       = 1'b0;
        dbg_win       = 1'b0;
        wait_cnt_nxt  = wait_cnt;
        rsp_owner_nxt = OWN_NONE;

        if (bus.dbg_req && dbg_starved) begin
            dbg_win = 1'b1;
        end else if (bus.cpu_req) begin
            cpu_win = 1'b1;
        end else if (bus.dbg_req) begin
            dbg_win = 1'b1;
        end

        // Counts consecutive denied debug cycles, saturating at the limit.
        if (!bus.dbg_req || dbg_win) begin
            wait_cnt_nxt = '0;
        end else if (!dbg_starved) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end

        // Only reads produce a response next cycle.
        if (cpu_win && (bus.cpu_memwrite == 2'b00)) begin
            rsp_owner_nxt = OWN_CPU;
        end else if (dbg_win) begin
            rsp_owner_nxt = OWN_DBG;
        end
    end

    // Outputs: grants, memory drive, response routing; all held at 0 in reset
    always_comb begin
        bus.cpu_gnt    = 1'b0;
        bus.dbg_gnt    = 1'b0;
        bus.cpu_rvalid = 1'b0;
        bus.dbg_rvalid = 1'b0;
        bus.cpu_rdata  = 64'h0;
        bus.dbg_rdata  = 64'h0;
        bus.mem_en     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_be     = 8'h00;
        bus.mem_wdata  = 64'h0;

        if (reset) begin
            bus.cpu_gnt = cpu_win;
            bus.dbg_gnt = dbg_win;

            if (cpu_win) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.cpu_adr[ADDR_W+2:3];
                unique case (bus.cpu_memwrite)
                    2'b00: bus.mem_be = 8'h00;
                    // Word data is replicated to both lanes; mem_be picks one.
                    2'b01: begin
                        bus.mem_be    = bus.cpu_adr[2] ? 8'hF0 : 8'h0F;
                        bus.mem_wdata = {2{bus.cpu_wdata[31:0]}};
                    end
                    default: begin
                        bus.mem_be    = 8'hFF;
                        bus.mem_wdata = bus.cpu_wdata;
                    end
                endcase
            end else if (dbg_win) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.dbg_addr;
            end

            if (rsp_owner == OWN_CPU) begin
                bus.cpu_rvalid = 1'b1;
                bus.cpu_rdata  = bus.mem_rdata;
            end
            if (rsp_owner == OWN_DBG) begin
                bus.dbg_rvalid = 1'b1;
                bus.dbg_rdata  = bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic. A reference model predicts grants and memory drive each
// cycle and queues expected read responses; a separate monitor pops and
// compares whenever a response is due.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned MAXWAIT = 4;
    localparam int unsigned NLINES  = 256;

    typedef struct {
        int          due;
        logic [63:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MAXWAIT(MAXWAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] init_val(int i);
        return {32'(i) * 32'h9E37_79B9, ~(32'(i) * 32'h85EB_CA6B)};
    endfunction

    // Synchronous memory: write at the edge, read data valid next cycle.
    // Garbage on mem_rdata when idle exposes missing rdata gating.
    logic [63:0] mem [NLINES];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < int'(NLINES); i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (bus.mem_en) begin
            for (int i = 0; i < 8; i++)
                if (bus.mem_be[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
            bus.mem_rdata <= mem[bus.mem_addr];
        end else begin
            bus.mem_rdata <= {$urandom, $urandom};
        end
    end

    // Reference model state
    logic [63:0] ref_mem [NLINES];
    rsp_t        cpu_q[$];
    rsp_t        dbg_q[$];
    int          dbg_wait = 0;
    int          dbg_age  = 0;
    logic        g_cpu = 1'b0;
    logic        g_dbg = 1'b0;
    logic        act_cpu_gnt = 1'b0;
    logic        act_dbg_gnt = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Predict this cycle's grant and memory drive from the arbitration rules.
    task automatic check_cycle();
        logic        ec, ed;
        logic [7:0]  ebe;
        logic [63:0] ewd, mask;
        logic [7:0]  eaddr;
        rsp_t        r;
        ec = 1'b0; ed = 1'b0; ebe = 8'h00; ewd = 64'h0; eaddr = 8'h00;
        if (reset) begin
            ed = bus.dbg_req && (dbg_wait == int'(MAXWAIT) || !bus.cpu_req);
            ec = bus.cpu_req && !ed;
        end
        if (ec) begin
            eaddr = 8'(bus.cpu_adr >> 3);
            if (bus.cpu_memwrite == 2'd1) begin
                ebe = ((bus.cpu_adr >> 2) % 2 == 1) ? 8'hF0 : 8'h0F;
                ewd = {2{bus.cpu_wdata[31:0]}};
            end else if (bus.cpu_memwrite != 2'd0) begin
                ebe = 8'hFF;
                ewd = bus.cpu_wdata;
            end
        end else if (ed) begin
            eaddr = bus.dbg_addr;
        end
        for (int i = 0; i < 8; i++) mask[8*i +: 8] = {8{ebe[i]}};

        act_cpu_gnt = bus.cpu_gnt;
        act_dbg_gnt = bus.dbg_gnt;
        chk("cpu_gnt", 64'(bus.cpu_gnt), 64'(ec));
        chk("dbg_gnt", 64'(bus.dbg_gnt), 64'(ed));
        chk("mem_en", 64'(bus.mem_en), 64'(ec | ed));
        if (ec || ed || !reset) begin
            chk("mem_addr", 64'(bus.mem_addr), 64'(eaddr));
            chk("mem_be", 64'(bus.mem_be), 64'(ebe));
        end
        if (!reset) chk("mem_wdata_rst", bus.mem_wdata, 64'h0);
        else if (ebe != 8'h00) chk("mem_wdata", bus.mem_wdata & mask, ewd & mask);

        if (ec && bus.cpu_memwrite == 2'd0) begin
            r.due = cyc + 1; r.data = ref_mem[eaddr]; cpu_q.push_back(r);
        end
        if (ed) begin
            r.due = cyc + 1; r.data = ref_mem[eaddr]; dbg_q.push_back(r);
        end
        for (int i = 0; i < 8; i++)
            if (ebe[i]) ref_mem[eaddr][8*i +: 8] = ewd[8*i +: 8];

        // Debug must never wait more than MAXWAIT denied cycles.
        if (reset && bus.dbg_req) begin
            if (bus.dbg_gnt) begin
                chk("dbg_latency_ok", 64'(dbg_age <= int'(MAXWAIT)), 64'd1);
                dbg_age = 0;
            end else begin
                dbg_age++;
            end
        end else begin
            dbg_age = 0;
        end

        if (reset && bus.dbg_req && !ed)
            dbg_wait = (dbg_wait + 1 > int'(MAXWAIT)) ? int'(MAXWAIT) : dbg_wait + 1;
        else
            dbg_wait = 0;
        g_cpu = ec;
        g_dbg = ed;
    endtask

    // Monitor: compare read responses against the scoreboard queues
    always @(negedge clk) begin : monitor
        logic ev;
        rsp_t r;
        if (cyc > 0) begin
            ev = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
            chk("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(ev));
            if (ev) begin
                r = cpu_q.pop_front();
                chk("cpu_rdata", bus.cpu_rdata, r.data);
            end else begin
                chk("cpu_rdata_idle", bus.cpu_rdata, 64'h0);
            end
            ev = (dbg_q.size() > 0) && (dbg_q[0].due == cyc);
            chk("dbg_rvalid", 64'(bus.dbg_rvalid), 64'(ev));
            if (ev) begin
                r = dbg_q.pop_front();
                chk("dbg_rdata", bus.dbg_rdata, r.data);
            end else begin
                chk("dbg_rdata_idle", bus.dbg_rdata, 64'h0);
            end
            chk("rvalid_exclusive", 64'(bus.cpu_rvalid & bus.dbg_rvalid), 64'd0);
        end
    end

    // One cycle: inputs were set at posedge+1; check at negedge.
    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic cpu_op(logic [1:0] code, logic [63:0] adr, logic [63:0] wd);
        int k = 0;
        bus.cpu_req = 1'b1; bus.cpu_memwrite = code; bus.cpu_adr = adr; bus.cpu_wdata = wd;
        do begin tick(); k++; end while (!g_cpu && k < 32);
        if (!g_cpu) chk("cpu_grant_timeout", 64'd0, 64'd1);
        bus.cpu_req = 1'b0;
    endtask

    task automatic dbg_op(logic [ADDR_W-1:0] line);
        int k = 0;
        bus.dbg_req = 1'b1; bus.dbg_addr = line;
        do begin tick(); k++; end while (!g_dbg && k < 32);
        if (!g_dbg) chk("dbg_grant_timeout", 64'd0, 64'd1);
        bus.dbg_req = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        cpu_q.delete();
        dbg_q.delete();
        dbg_wait = 0;
        dbg_age  = 0;
    endtask

    initial begin
        int first;
        for (int i = 0; i < int'(NLINES); i++) ref_mem[i] = init_val(i);
        reset = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_memwrite = 2'd0; bus.cpu_adr = 64'h40; bus.cpu_wdata = 64'h0;
        bus.dbg_req = 1'b1; bus.dbg_addr = 8'd3;
        @(posedge clk);
        #1;

        // Reset held with both requests high, then release
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("post_reset_cpu_gnt", 64'(act_cpu_gnt), 64'd1);
        idle(2);

        // Word write to upper lane, then read back
        cpu_op(2'b01, 64'd84, 64'hDEAD_BEEF_0000_0007);
        cpu_op(2'b00, 64'd84, 64'h0);
        idle(1);

        // Doubleword write, debug readback
        cpu_op(2'b10, 64'd128, 64'h0123_4567_89AB_CDEF);
        dbg_op(8'd16);
        idle(2);

        // Contention: debug wins after MAXWAIT denials, CPU stalls one cycle
        bus.cpu_req = 1'b1; bus.cpu_memwrite = 2'b00; bus.cpu_adr = 64'd128;
        bus.dbg_req = 1'b1; bus.dbg_addr = 8'd10;
        first = -1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (first >= 0 && k == first + 1) chk("cpu_regrant", 64'(act_cpu_gnt), 64'd1);
            if (act_dbg_gnt && first < 0) begin
                first = k;
                chk("contention_cpu_stall", 64'(act_cpu_gnt), 64'd0);
                bus.dbg_req = 1'b0;
            end
        end
        chk("contention_dbg_cycle", 64'(first), 64'(MAXWAIT));
        idle(2);

        // Alternating CPU/debug reads, pipelined
        for (int k = 0; k < 8; k++) begin
            bus.cpu_req = (k % 2 == 0);
            bus.dbg_req = (k % 2 == 1);
            bus.cpu_memwrite = 2'b00;
            bus.cpu_adr  = 64'(k * 8 + 8);
            bus.dbg_addr = 8'(k + 10);
            tick();
        end
        idle(2);

        // Reset in the cycle after a CPU read grant discards the response
        cpu_op(2'b00, 64'd84, 64'h0);
        apply_reset();
        tick();
        tick();
        reset = 1'b1;
        idle(3);

        // Random traffic; requests and operands held until granted
        for (int n = 0; n < 800; n++) begin
            if (!bus.cpu_req && $urandom_range(0, 3) != 0) begin
                bus.cpu_req      = 1'b1;
                bus.cpu_memwrite = 2'($urandom);
                bus.cpu_adr      = {$urandom, $urandom};
                bus.cpu_adr[10:3] = 8'($urandom_range(0, 15));
                bus.cpu_wdata    = {$urandom, $urandom};
            end
            if (!bus.dbg_req && $urandom_range(0, 3) == 0) begin
                bus.dbg_req  = 1'b1;
                bus.dbg_addr = 8'($urandom_range(0, 15));
            end
            tick();
            if (g_cpu) bus.cpu_req = 1'b0;
            if (g_dbg) bus.dbg_req = 1'b0;
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified instruction/data memory between the multicycle CPU core and the debug read port used by the bench/board monitor. Each cycle it picks one requester, drives the memory port, converts byte addresses and `memwrite` codes into line index plus byte enables, and routes the one-cycle-late read data back to the owner. The CPU has fixed priority. A wait counter guarantees that debug reads are served within a bounded time.

## Interface
- `ADDR_W`, 8: memory line-index width. One line = 64 bits (8 bytes).
- `MAXWAIT`, 4: the number of consecutive denied debug cycles after which debug takes priority. Legal range 1..15.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. Reset is asserted when `reset`=0.
- `cpu_req` in 1: CPU requests an access this cycle.
- `cpu_memwrite` in 2: write code.
  - 00 = read.
  - 01 = 32-bit word write.
  - 10 = 64-bit doubleword write.
  - 11 = treated as 10.
- `cpu_adr` in 64: CPU byte address.
- `cpu_wdata` in 64: CPU write data. A word write uses bits [31:0].
- `cpu_gnt` out 1: the CPU access is accepted this cycle.
- `cpu_rvalid` out 1: `cpu_rdata` is valid, one cycle after a granted CPU read.
- `cpu_rdata` out 64: read line.
- `dbg_req` in 1: debug read request. Debug is read-only.
- `dbg_addr` in ADDR_W: debug line index.
- `dbg_gnt` out 1: the debug access is accepted this cycle.
- `dbg_rvalid` out 1: `dbg_rdata` is valid.
- `dbg_rdata` out 64: debug read line.
- `mem_en` out 1: memory access strobe.
- `mem_addr` out ADDR_W: line index.
- `mem_be` out 8: byte write enables. 0 means read.
- `mem_wdata` out 64: write data, already lane-aligned.
- `mem_rdata` in 64: synchronous memory read data. It is valid in the cycle after `mem_en`.

## Operation
- State registers:
  - `wait_cnt` (4 bits).
  - `rsp_owner` (2 bits: NONE, CPU, DBG).
- Arbitration is combinational from the inputs and `wait_cnt`. Decision order:
  - If `dbg_req`=1 and `wait_cnt`==MAXWAIT: grant DBG.
  - Else if `cpu_req`=1: grant CPU.
  - Else if `dbg_req`=1: grant DBG.
  - Else: no grant.
- Exactly one or zero grants per cycle. `cpu_gnt` and `dbg_gnt` are never both 1.
- Requesters hold their request and operands stable until granted. The arbiter does not latch denied requests.
- Memory drive on a grant:
  - `mem_en`=1.
  - For CPU: `mem_addr` = `cpu_adr[ADDR_W+2:3]`. Upper address bits are ignored.
  - For DBG: `mem_addr` = `dbg_addr`.
- Byte enables and write data (CPU only):
  - Read: `mem_be`=8'h00.
  - Doubleword write: `mem_be`=8'hFF, `mem_wdata`=`cpu_wdata`.
  - Word write with `cpu_adr[2]`=0: `mem_be`=8'h0F, data in [31:0].
  - Word write with `cpu_adr[2]`=1: `mem_be`=8'hF0, `cpu_wdata[31:0]` copied to [63:32].
  - DBG grant: `mem_be`=8'h00.
- `wait_cnt` next value:
  - Cleared when `dbg_req`=0 or `dbg_gnt`=1.
  - Otherwise incremented, saturating at MAXWAIT.
- `rsp_owner` next value:
  - CPU for a granted CPU read.
  - DBG for a granted debug read.
  - NONE otherwise, including CPU writes.
- Response routing from `rsp_owner`:
  - CPU: `cpu_rvalid`=1, `cpu_rdata`=`mem_rdata`.
  - DBG: `dbg_rvalid`=1, `dbg_rdata`=`mem_rdata`.
  - Both rdata outputs read 0 when not valid.
- Writes produce no response pulse.

## Timing
- Reset (`reset`=0, asynchronous): `wait_cnt`=0 and `rsp_owner`=NONE. While asserted, all outputs are forced to 0: grants, rvalids, rdata, `mem_en`, `mem_be`, `mem_addr`, `mem_wdata`.
- Reset mid-read: the pending response is discarded. No rvalid appears after reset is released.
- Release is sampled at the first rising edge with `reset`=1. A grant is possible in that same cycle.
- Grant latency: 0 cycles for an uncontested request (grant in the same cycle as the request).
- Read latency: rvalid exactly 1 cycle after the grant.
- Throughput: back-to-back grants every cycle, with reads pipelined one deep.
- Write ordering: a CPU write granted in cycle N followed by any read of the same line granted in cycle N+1 returns the written data (the memory writes at edge N).
- Simultaneous `cpu_req` and `dbg_req`: CPU wins until `wait_cnt` reaches MAXWAIT.
  - Debug is therefore granted no later than MAXWAIT+1 cycles after `dbg_req` rises.
  - On that cycle `cpu_gnt`=0 and the CPU stalls exactly one cycle.
- `wait_cnt` saturates and never wraps.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with both requests high → all outputs 0. After release, the first cycle has `cpu_gnt`=1.
- Word write then read:
  - CPU word write of 7 at byte address 84 → `mem_addr`=10, `mem_be`=8'hF0, `mem_wdata[63:32]`=7, no rvalid.
  - CPU read of 84 in the next cycle → `cpu_rvalid`=1 one cycle later, `cpu_rdata[63:32]`=7.
- Doubleword write:
  - CPU `memwrite`=10 with data 64'h0123_4567_89AB_CDEF at byte address 128 → `mem_addr`=16, `mem_be`=8'hFF.
  - Debug read of line 16 → `dbg_rdata`=64'h0123_4567_89AB_CDEF, `dbg_rvalid` one cycle after `dbg_gnt`.
- Contention with MAXWAIT=4:
  - `cpu_req` held high continuously, `dbg_req` rises at cycle 0 → `cpu_gnt`=1 in cycles 0-3.
  - `dbg_gnt`=1 in cycle 4 with `cpu_gnt`=0. `cpu_gnt`=1 again in cycle 5.
  - `wait_cnt`=0 after cycle 4.
- Pipelined reads: alternating CPU/debug reads on consecutive cycles → rvalids alternate each cycle with the correct data on each port and never both 1.
- Reset mid-read: assert `reset`=0 in the cycle after a CPU read grant → no `cpu_rvalid` appears. After release, `rsp_owner` is NONE.
